// File: rtl/integ_pkg.sv
// rtl/integ_pkg.sv - shared encodings and width constants for the multichannel integrator
package integ_pkg;

  // Update modes; the reserved encoding 2'd3 falls through to pure accumulate.
  localparam logic [1:0] MODE_PURE  = 2'd0;
  localparam logic [1:0] MODE_LEAKY = 2'd1;
  localparam logic [1:0] MODE_DUMP  = 2'd2;

  // Headroom bits carried above ACC_W so the raw update never wraps before
  // the clamp/overflow decision is made.
  localparam int WIDE_OFS = 2;

endpackage

// File: rtl/integ_update.sv
// rtl/integ_update.sv - combinational per-sample accumulator update with clamp/wrap
//
// Ports:
//   y          in  ACC_W  current accumulator (signed)
//   x          in  IN_W   input sample (signed)
//   mode       in  2      update mode (integ_pkg encodings)
//   k          in  4      leaky decay shift, 0 = no decay
//   sat_enable in  1      clamp to [sat_neg, sat_pos] instead of wrapping
//   sat_pos    in  ACC_W  signed upper bound
//   sat_neg    in  ACC_W  signed lower bound
//   next_y     out ACC_W  updated accumulator
//   sat        out 1      result was clamped or wrapped
//
// Build option: INTEG_ROUND_EN selects round-half-up for the leaky decay term.
module integ_update
  import integ_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int ACC_W = 16
) (
  input  logic [ACC_W-1:0] y,
  input  logic [IN_W-1:0]  x,
  input  logic [1:0]       mode,
  input  logic [3:0]       k,
  input  logic             sat_enable,
  input  logic [ACC_W-1:0] sat_pos,
  input  logic [ACC_W-1:0] sat_neg,
  output logic [ACC_W-1:0] next_y,
  output logic             sat
);

  localparam int W = ACC_W + WIDE_OFS;

  logic signed [W-1:0] yw, xw, decay, sum, pos_w, neg_w;
  logic [WIDE_OFS:0]   top_bits;
`ifdef INTEG_ROUND_EN
  logic signed [W-1:0] rnd;
`endif

  always_comb begin
    yw    = {{WIDE_OFS{y[ACC_W-1]}}, y};
    xw    = {{(W-IN_W){x[IN_W-1]}}, x};
    pos_w = {{WIDE_OFS{sat_pos[ACC_W-1]}}, sat_pos};
    neg_w = {{WIDE_OFS{sat_neg[ACC_W-1]}}, sat_neg};
    decay = '0;
`ifdef INTEG_ROUND_EN
    rnd   = '0;
`endif
    if (mode == MODE_LEAKY && k != 4'd0) begin
`ifdef INTEG_ROUND_EN
      rnd   = W'(1) <<< (k - 4'd1);
      decay = (yw + rnd) >>> k;
`else
      decay = yw >>> k;
`endif
    end
    sum = yw - decay + xw;

    // Sign bits above the ACC_W-1 position must all agree for the result
    // to be representable without wrap.
    top_bits = sum[W-1:ACC_W-1];
    next_y   = sum[ACC_W-1:0];
    sat      = 1'b0;
    if (sat_enable) begin
      if (sum > pos_w) begin
        next_y = sat_pos;
        sat    = 1'b1;
      end else if (sum < neg_w) begin
        next_y = sat_neg;
        sat    = 1'b1;
      end
    end else begin
      sat = !((&top_bits) || !(|top_bits));
    end
  end

endmodule

// File: rtl/integrator_multich.sv
// rtl/integrator_multich.sv - time-multiplexed NUM_CH-channel integrator with valid/ready handshakes
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   enable                    global enable; low blocks input, output still drains
//   in_valid/in_ready         sample handshake; in_ch, in_data carry the sample
//   mode, decay_shift         update mode and leaky shift, sampled per accepted sample
//   dump_len                  integrate-and-dump window length (0 acts as 1)
//   sat_enable/sat_pos/neg    clamp control
//   clr_valid/clr_ch          per-channel clear (wins over a same-channel sample)
//   out_valid/out_ready       result handshake; out_ch, out_data, out_sat carry the result
//   ovf_sticky                per-channel sticky overflow
//
// Build option: INTEG_ROUND_EN (round-half-up leaky decay, inside integ_update).
module integrator_multich
  import integ_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH),
  parameter int IN_W   = 8,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [IN_W-1:0]   in_data,
  input  logic [1:0]        mode,
  input  logic [3:0]        decay_shift,
  input  logic [CNT_W-1:0]  dump_len,
  input  logic              sat_enable,
  input  logic [ACC_W-1:0]  sat_pos,
  input  logic [ACC_W-1:0]  sat_neg,
  input  logic              clr_valid,
  input  logic [CH_W-1:0]   clr_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_sat,
  output logic [NUM_CH-1:0] ovf_sticky
);

  logic [ACC_W-1:0] acc_q [NUM_CH];
  logic [CNT_W-1:0] cnt_q [NUM_CH];

  logic             accept, take, is_dump, dump_hit, emit, hold;
  logic [CNT_W-1:0] cnt_nxt, dump_lim;
  logic [ACC_W-1:0] upd_y;
  logic             upd_sat;

  assign in_ready = enable && (!out_valid || out_ready);
  assign hold     = out_valid && !out_ready;

  // State is written back at the same edge the sample is accepted, so a
  // back-to-back sample on the same channel always reads the fresh value.
  integ_update #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_update (
    .y          (acc_q[in_ch]),
    .x          (in_data),
    .mode       (mode),
    .k          (decay_shift),
    .sat_enable (sat_enable),
    .sat_pos    (sat_pos),
    .sat_neg    (sat_neg),
    .next_y     (upd_y),
    .sat        (upd_sat)
  );

  always_comb begin
    accept   = in_valid && in_ready;
    // A clear on the sample's own channel consumes the sample without effect.
    take     = accept && !(clr_valid && clr_ch == in_ch);
    is_dump  = (mode == MODE_DUMP);
    cnt_nxt  = cnt_q[in_ch] + CNT_W'(1);
    dump_lim = (dump_len == '0) ? CNT_W'(1) : dump_len;
    dump_hit = (cnt_nxt == dump_lim);
    emit     = take && (!is_dump || dump_hit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      ovf_sticky <= '0;
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_data   <= '0;
      out_sat    <= 1'b0;
    end else begin
      if (take) begin
        if (is_dump && dump_hit) begin
          acc_q[in_ch] <= '0;
          cnt_q[in_ch] <= '0;
        end else begin
          acc_q[in_ch] <= upd_y;
          if (is_dump) begin
            cnt_q[in_ch] <= cnt_nxt;
          end
        end
        if (upd_sat) begin
          ovf_sticky[in_ch] <= 1'b1;
        end
      end
      // Placed after the sample write so a clear always has the last word.
      if (clr_valid) begin
        acc_q[clr_ch]      <= '0;
        cnt_q[clr_ch]      <= '0;
        ovf_sticky[clr_ch] <= 1'b0;
      end
      if (!hold) begin
        out_valid <= emit;
        if (emit) begin
          out_ch   <= in_ch;
          out_data <= upd_y;
          out_sat  <= upd_sat;
        end
      end
    end
  end

endmodule
